// File: rtl/teclado_matriz.sv
// Scanning controller for a 2x4 keypad: row scan, per-key debounce, press pulses.
module teclado_matriz #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] colunas_in,
    input  logic       habilita,
    output logic [1:0] linhas_out,
    output logic [7:0] botoes,
    output logic [7:0] pressionado
);

    localparam int unsigned N_ROWS = 2;
    localparam int unsigned N_COLS = 4;
    localparam int unsigned N_KEYS = N_ROWS * N_COLS;
    localparam int unsigned SW     = $clog2(SCAN_DIV);
    localparam int unsigned CW     = 4;

    typedef enum logic {
        ROW0 = 1'b0,
        ROW1 = 1'b1
    } row_t;

    row_t              row_q, row_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [1:0]        linhas_q, linhas_d;
    logic [3:0]        col_s1_q, col_s2_q;
    logic [CW-1:0]     cnt_q [N_KEYS];
    logic [CW-1:0]     cnt_d [N_KEYS];
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [N_KEYS-1:0] botoes_q, botoes_d;
    logic              sample_c;
    logic              raw_c;

    // State registers: scan position, synchronizer, debounce and pulse state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q    <= ROW0;
            slot_q   <= '0;
            linhas_q <= 2'b10;
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
            press_q  <= '0;
            pend_q   <= '0;
            botoes_q <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            row_q    <= row_d;
            slot_q   <= slot_d;
            linhas_q <= linhas_d;
            col_s1_q <= colunas_in;
            col_s2_q <= col_s1_q;
            press_q  <= press_d;
            pend_q   <= pend_d;
            botoes_q <= botoes_d;
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Next-state: row advance at end of slot, debounce on the active row, pulse staging.
    always_comb begin
        row_d    = row_q;
        slot_d   = slot_q + SW'(1);
        press_d  = press_q;
        pend_d   = '0;
        botoes_d = pend_q;
        raw_c    = 1'b0;
        cnt_d    = cnt_q;
        sample_c = (slot_q == SW'(SCAN_DIV - 1));

        if (sample_c) begin
            slot_d = '0;
            row_d  = (row_q == ROW0) ? ROW1 : ROW0;
            for (int r = 0; r < N_ROWS; r++) begin
                if (row_q == ((r == 0) ? ROW0 : ROW1)) begin
                    for (int c = 0; c < N_COLS; c++) begin
                        raw_c = ~col_s2_q[c];
                        if (raw_c == press_q[r*N_COLS + c]) begin
                            cnt_d[r*N_COLS + c] = '0;
                        end else if (cnt_q[r*N_COLS + c] == CW'(DEBOUNCE_CNT - 1)) begin
                            press_d[r*N_COLS + c] = raw_c;
                            cnt_d[r*N_COLS + c]   = '0;
                            // A rising flip arms a pulse only if enabled right now.
                            pend_d[r*N_COLS + c]  = raw_c & habilita;
                        end else begin
                            cnt_d[r*N_COLS + c] = cnt_q[r*N_COLS + c] + CW'(1);
                        end
                    end
                end
            end
        end

        linhas_d = (row_d == ROW0) ? 2'b10 : 2'b01;
    end

    assign linhas_out  = linhas_q;
    assign botoes      = botoes_q;
    assign pressionado = press_q;

endmodule

// File: doc/teclado_matriz.md
Name: teclado_matriz

Overview:
- Scanning controller for the 2x4 push-button keypad that feeds the puzzle's LED-matrix controller.
- Drives one keypad row low at a time and reads the 4 column lines.
- Debounces each of the 8 keys independently.
- Emits single-cycle press pulses on the 8-bit button bus that the LED-matrix controller consumes as toggle commands. Also provides debounced key levels for the control unit.

Parameters:
SCAN_DIV, 4, clocks per row slot; legal minimum 4 (≥2 sync cycles + settle)
DEBOUNCE_CNT, 3, consecutive identical samples of a key needed to change its debounced state; legal range 1..15
N_ROWS, 2, keypad rows (fixed at 2 for this keypad; not a general parameter)
N_COLS, 4, keypad columns (fixed at 4)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
colunas_in  input  4  raw keypad column lines; pulled up externally, 0 = key closed on the currently driven row
habilita  input  1  1 = press pulses allowed; 0 = pulses suppressed (debounce keeps running)
linhas_out  output  2  row drive, active-low, exactly one bit low at all times
botoes  output  8  one-cycle press pulses; bit index = row*4 + col
pressionado  output  8  debounced key level, 1 = held

Behaviour:
- Reset (rst=0, asynchronous):
  - linhas_out=2'b10 (row 0 driven); row index 0; slot counter 0.
  - Both column synchronizer stages = 4'b1111.
  - pressionado=0, botoes=0, all per-key debounce counters 0.
- Input sync: colunas_in passes through a 2-flop synchronizer. Only the second-stage value (col_s) is used.
- Scan FSM:
  - Slot counter runs 0..SCAN_DIV-1.
  - At count SCAN_DIV-1: sample col_s for the current row, advance the row (0→1→0, wrap), and update linhas_out on the same edge.
  - Row 0 → linhas_out=2'b10; row 1 → 2'b01.
  - Frame period = N_ROWS*SCAN_DIV clocks (8 at defaults). Each key is sampled once per frame.
- Sampling: for key k = row*4+c, raw_k = ~col_s[c], taken only in that row's sample cycle. Keys of the other row are untouched in that cycle.
- Debounce, per key, evaluated only on that key's sample cycle:
  - raw_k == pressionado[k]: counter clears.
  - raw_k != pressionado[k] and counter == DEBOUNCE_CNT-1: pressionado[k] flips, counter clears.
  - Otherwise the counter increments.
  - Counter width is 4 bits.
  - Any single disagreeing sample in a run restarts the count; in-frame bounces shorter than one frame are invisible.
- Pulse generation:
  - botoes[k]=1 for exactly the one clock after pressionado[k] goes 0→1, and only if habilita=1 on the flip cycle.
  - No pulse on a 1→0 release. No repeat while held.
  - habilita=0 during the flip cycle loses that press; no deferred pulse.
- Simultaneous keys:
  - Keys in the same row that qualify on the same sample produce pulses in the same cycle. Keys in different rows produce pulses SCAN_DIV clocks apart.
  - The downstream controller applies simultaneous pulses as simultaneous toggles (XOR semantics), so no serialization is needed here.
- Latency: a clean press held from before its row's sample cycle sets pressionado after DEBOUNCE_CNT samples, i.e. at most (DEBOUNCE_CNT+1)*frame + 2 clocks. botoes follows one clock later.
- Reset mid-operation: all debounce state is lost. A key still held after rst releases is treated as a new press and pulses after a full debounce.
- botoes and pressionado are registered outputs; there are no combinational paths from inputs.

Test Plan:
- Reset: hold rst=0 with random colunas_in → linhas_out=2'b10, botoes=0, pressionado=0. Release and run 16 clks with colunas_in=4'hF → linhas_out alternates 10/01 every 4 clks; botoes stays 0.
- Clean press of key 5 (drive colunas_in[1]=0 whenever linhas_out=01) → pressionado[5]=1 within 3 frames + 2 clks; botoes=8'b0010_0000 for exactly 1 clk. Hold 100 clks → no further pulses. Release → pressionado[5]=0 after 3 samples; no pulse.
- Bounce on key 0: colunas_in[0] alternates pressed/released on successive row-0 samples for 10 frames → pressionado=0, botoes=0 throughout.
- Simultaneous keys 0 and 2 (same row) → a single cycle with botoes=8'b0000_0101. Keys 0 and 7 (different rows) → botoes=8'h01 and 8'h80 exactly 4 clks apart.
- habilita=0 during press of key 3 → pressionado[3]=1, botoes stays 0. Set habilita=1 while the key is still held → still no pulse.
- Assert rst for 1 clk mid-hold of key 6 → outputs clear immediately. After release of rst with the key still held → pressionado[6] reasserts and a single 8'b0100_0000 pulse is seen after a full debounce.
